stage4_issue_scoreboard: RTL and testbench

Parametrised issue-stage scoreboard and serialisation controller for the stage4 pipeline. It sits between the decode queue output and execute. It tracks in-flight register writes from multiple writeback ports, including long-latency multiply/divide/vector ops, and withholds issue on hazards. It also drains the machine before and during serialising instructions (vsetvl, CSR, fence). It is the multi-port, counted, stateful successor to the single-forwarding-path hazard check.

---
 rtl/rv32i_types_pkg.sv | 20 ++
 rtl/stage4_sb_counter.sv | 61 ++++++
 rtl/stage4_issue_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_stage4_issue_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared types for the stage4 pipeline: register selector, scoreboard FSM
// states and the per-register in-flight counter sizing.
package rv32i_types_pkg;

    typedef logic [4:0] regsel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } scoreboard_state_t;

    localparam int SB_MAX_INFLIGHT = 3;

    // Counter width able to hold 0..max_inflight.
    function automatic int sb_cnt_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/stage4_sb_counter.sv
// Per-register outstanding-write counter: one increment from issue, up to
// NUM_WB_PORTS decrements from writeback, saturating at zero with a sticky
// underflow flag. Reports how many decrements actually landed so the top
// can keep the global in-flight total consistent with the per-register counts.
module stage4_sb_counter
    import rv32i_types_pkg::*;
#(
    parameter int      NUM_WB_PORTS = 2,
    parameter int      MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int      CNT_W        = sb_cnt_width(MAX_INFLIGHT),
    parameter int      DEC_W        = $clog2(NUM_WB_PORTS + 1),
    parameter regsel_t REG_IDX      = 5'd1
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         clear,
    input  logic                         inc,
    input  logic    [NUM_WB_PORTS-1:0]   wb_valid,
    input  regsel_t [NUM_WB_PORTS-1:0]   wb_rd,
    output logic    [CNT_W-1:0]          count,
    output logic    [DEC_W-1:0]          dec_applied,
    output logic                         underflow
);

    logic [CNT_W-1:0] count_d;
    logic             underflow_d;
    int               hits;
    int               avail;
    int               dec;

    // Net delta of this cycle's issue and writebacks, clamped at zero.
    always_comb begin
        hits = 0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_rd[p] == REG_IDX)) begin
                hits = hits + 1;
            end
        end
        avail       = int'(count) + (inc ? 1 : 0);
        dec         = (hits > avail) ? avail : hits;
        count_d     = CNT_W'(avail - dec);
        dec_applied = DEC_W'(dec);
        underflow_d = (hits > avail);
    end

    // Count register; flush clears it, underflow is sticky until reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count     <= '0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= '0;
        end else begin
            count <= count_d;
            if (underflow_d) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage4_issue_scoreboard.sv
// Issue-stage scoreboard and serialisation controller for stage4.
// Tracks outstanding register writes per register and globally, withholds
// issue on RAW / structural (and optionally WAW) hazards, and drains the
// machine around serialising instructions.
// Optional feature macro: SCOREBOARD_WAW_STALL_EN (stall a write to a
// register that already has an outstanding write).
//
// state  | meaning
// IDLE   | normal issue; serialising head either fires or starts draining
// DRAIN  | waiting for inflight == 0 before the serialising head fires
// SERIAL | serialising instruction executing alone; wait for serial_done
module stage4_issue_scoreboard
    import rv32i_types_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int NUM_WB_PORTS = 2,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int TOT_W        = 8
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        issue_valid,
    input  regsel_t                     issue_rs1,
    input  regsel_t                     issue_rs2,
    input  regsel_t                     issue_rd,
    input  logic                        issue_rd_wen,
    input  logic                        issue_serialize,
    output logic                        issue_ready,
    input  logic    [NUM_WB_PORTS-1:0]  wb_valid,
    input  regsel_t [NUM_WB_PORTS-1:0]  wb_rd,
    input  logic                        serial_done,
    input  logic                        flush,
    output logic    [NUM_REGS-1:0]      pending,
    output logic    [TOT_W-1:0]         inflight,
    output logic                        busy,
    output logic                        err_underflow
);

    localparam int CNT_W = sb_cnt_width(MAX_INFLIGHT);
    localparam int DEC_W = $clog2(NUM_WB_PORTS + 1);

    logic [NUM_REGS-1:0][CNT_W-1:0] count;
    logic [NUM_REGS-1:0][DEC_W-1:0] dec_applied;
    logic [NUM_REGS-1:0]            uf_flag;
    logic [TOT_W-1:0]               inflight_d;
    scoreboard_state_t              state, state_d;
    logic                           fire;
    logic                           inc_en;
    logic                           raw_hazard;
    logic                           struct_hazard;
    logic                           waw_hazard;
    logic                           normal_ok;

    // x0 is hardwired: never pending, never counted.
    assign count[0]       = '0;
    assign dec_applied[0] = '0;
    assign uf_flag[0]     = 1'b0;

    assign fire   = issue_valid && issue_ready;
    assign inc_en = fire && issue_rd_wen && (issue_rd != '0);

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
            stage4_sb_counter #(
                .NUM_WB_PORTS (NUM_WB_PORTS),
                .MAX_INFLIGHT (MAX_INFLIGHT),
                .CNT_W        (CNT_W),
                .DEC_W        (DEC_W),
                .REG_IDX      (regsel_t'(r))
            ) u_cnt (
                .CLK         (CLK),
                .nRST        (nRST),
                .clear       (flush),
                .inc         (inc_en && (issue_rd == regsel_t'(r))),
                .wb_valid    (wb_valid),
                .wb_rd       (wb_rd),
                .count       (count[r]),
                .dec_applied (dec_applied[r]),
                .underflow   (uf_flag[r])
            );
        end
    endgenerate

    // Per-register pending view and hazard checks against registered state only.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (count[r] != '0);
        end
        raw_hazard    = ((issue_rs1 != '0) && pending[issue_rs1]) ||
                        ((issue_rs2 != '0) && pending[issue_rs2]);
        struct_hazard = issue_rd_wen && (count[issue_rd] == CNT_W'(MAX_INFLIGHT));
`ifdef SCOREBOARD_WAW_STALL_EN
        waw_hazard    = issue_rd_wen && (issue_rd != '0) && pending[issue_rd];
`else
        waw_hazard    = 1'b0;
`endif
        normal_ok     = !(raw_hazard || struct_hazard || waw_hazard);
    end

    // Next-state and issue_ready; flush forces IDLE and blocks issue.
    always_comb begin
        state_d     = state;
        issue_ready = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_serialize) begin
                        if (inflight == '0) begin
                            issue_ready = normal_ok;
                            if (issue_valid && normal_ok) begin
                                state_d = SERIAL;
                            end
                        end else if (issue_valid) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        issue_ready = normal_ok;
                    end
                end
                DRAIN: begin
                    issue_ready = (inflight == '0) && normal_ok;
                    if (issue_valid && issue_ready) begin
                        state_d = issue_serialize ? SERIAL : IDLE;
                    end
                end
                SERIAL: begin
                    if (serial_done) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Global total moves by exactly what the per-register counters applied.
    always_comb begin
        int total_dec;
        total_dec = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            total_dec = total_dec + int'(dec_applied[r]);
        end
        inflight_d = TOT_W'(int'(inflight) + (inc_en ? 1 : 0) - total_dec);
    end

    // State and global in-flight registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            inflight <= '0;
        end else if (flush) begin
            state    <= IDLE;
            inflight <= '0;
        end else begin
            state    <= state_d;
            inflight <= inflight_d;
        end
    end

    assign busy          = (state != IDLE);
    assign err_underflow = |uf_flag;

endmodule

// File: tb/tb_stage4_issue_scoreboard.sv
// Directed bench for stage4_issue_scoreboard: a table of per-cycle vectors
// with hand-computed expectations, plus hand-written async-reset sequences.
module tb_stage4_issue_scoreboard;

`ifdef SCOREBOARD_WAW_STALL_EN
    localparam bit WAW = 1'b1;
`else
    localparam bit WAW = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_wen, issue_serialize;
    logic        issue_ready;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic        serial_done, flush;
    logic [31:0] pending;
    logic [7:0]  inflight;
    logic        busy, err_underflow;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    stage4_issue_scoreboard dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_rd        (issue_rd),
        .issue_rd_wen    (issue_rd_wen),
        .issue_serialize (issue_serialize),
        .issue_ready     (issue_ready),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .serial_done     (serial_done),
        .flush           (flush),
        .pending         (pending),
        .inflight        (inflight),
        .busy            (busy),
        .err_underflow   (err_underflow)
    );

    typedef struct {
        string       name;
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        wen, ser;
        logic [1:0]  wbv;
        logic [4:0]  wb0, wb1;
        logic        sdone, fl;
        logic        e_ready;
        logic [7:0]  e_infl;
        logic [31:0] e_pend;
        logic        e_busy, e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                       input logic ser, input logic [1:0] wbv, input logic [4:0] wb0,
                       input logic [4:0] wb1, input logic sdone, input logic fl,
                       input logic e_ready, input logic [7:0] e_infl,
                       input logic [31:0] e_pend, input logic e_busy, input logic e_err);
        vec_t t;
        t.name = name; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wen = wen;
        t.ser = ser; t.wbv = wbv; t.wb0 = wb0; t.wb1 = wb1; t.sdone = sdone; t.fl = fl;
        t.e_ready = e_ready; t.e_infl = e_infl; t.e_pend = e_pend;
        t.e_busy = e_busy; t.e_err = e_err;
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic ser,
                         input logic [1:0] wbv, input logic [4:0] wb0, input logic [4:0] wb1,
                         input logic sdone, input logic fl);
        issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_rd_wen = wen; issue_serialize = ser; wb_valid = wbv;
        wb_rd = {wb1, wb0}; serial_done = sdone; flush = fl;
    endtask

    initial begin
        //  name        v rs1 rs2 rd wen ser wbv  wb0 wb1 sd fl | rdy infl pend busy err
        add("raw_prod",  1, 0, 0, 5, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h20, 0, 0);
        add("raw_blk1",  1, 5, 0, 6, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 32'h20, 0, 0);
        add("raw_blk2",  1, 5, 0, 6, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 32'h20, 0, 0);
        add("raw_blk3",  1, 5, 0, 6, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 32'h20, 0, 0);
        add("raw_wb",    1, 5, 0, 6, 1, 0, 2'b01, 5, 0, 0, 0,  0, 0, 32'h0,  0, 0);
        add("raw_fire",  1, 5, 0, 6, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h40, 0, 0);
        add("raw_wb6",   0, 0, 0, 0, 0, 0, 2'b10, 0, 6, 0, 0,  1, 0, 32'h0,  0, 0);
        add("ser_p1",    1, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h2,  0, 0);
        add("ser_p2",    1, 0, 0, 2, 1, 0, 2'b00, 0, 0, 0, 0,  1, 2, 32'h6,  0, 0);
        add("ser_drain", 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 2, 32'h6,  1, 0);
        add("ser_wb1",   1, 0, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0,  0, 1, 32'h4,  1, 0);
        add("ser_wb2",   1, 0, 0, 0, 0, 1, 2'b01, 2, 0, 0, 0,  0, 0, 32'h0,  1, 0);
        add("ser_fire",  1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0,  1, 0, 32'h0,  1, 0);
        add("ser_blk",   1, 0, 0, 3, 1, 0, 2'b00, 0, 0, 0, 0,  0, 0, 32'h0,  1, 0);
        add("ser_done",  1, 0, 0, 3, 1, 0, 2'b00, 0, 0, 1, 0,  0, 0, 32'h0,  0, 0);
        add("ser_next",  1, 0, 0, 3, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h8,  0, 0);
        add("ser_wb3",   0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0, 0,  1, 0, 32'h0,  0, 0);
        add("st_f1",     1, 0, 0, 7, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h80, 0, 0);
        add("st_f2",     1, 0, 0, 7, 1, 0, 2'b00, 0, 0, 0, 0,  !WAW, WAW ? 8'd1 : 8'd2, 32'h80, 0, 0);
        add("st_f3",     1, 0, 0, 7, 1, 0, 2'b00, 0, 0, 0, 0,  !WAW, WAW ? 8'd1 : 8'd3, 32'h80, 0, 0);
        add("st_full",   1, 0, 0, 7, 1, 0, 2'b00, 0, 0, 0, 0,  0, WAW ? 8'd1 : 8'd3, 32'h80, 0, 0);
        add("st_dualwb", 1, 0, 0, 7, 1, 0, 2'b11, 7, 7, 0, 0,  0, WAW ? 8'd0 : 8'd1,
            WAW ? 32'h0 : 32'h80, 0, WAW);
        add("st_last",   0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0,  1, 0, 32'h0,  0, WAW);
        add("uf_wb9",    0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0,  1, 0, 32'h0,  0, 1);
        add("x0_issue",  1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0,  1, 0, 32'h0,  0, 1);
        add("x0_wb",     0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0,  1, 0, 32'h0,  0, 1);
        add("waw_f1",    1, 0, 0, 3, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h8,  0, 1);
        add("waw_f2",    1, 0, 0, 3, 1, 0, 2'b00, 0, 0, 0, 0,  !WAW, WAW ? 8'd1 : 8'd2, 32'h8, 0, 1);
        add("waw_wb1",   0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0, 0,  1, WAW ? 8'd0 : 8'd1,
            WAW ? 32'h0 : 32'h8, 0, 1);
        add("waw_wb2",   0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0, 0,  1, 0, 32'h0,  0, 1);
        add("fl_p10",    1, 0, 0, 10, 1, 0, 2'b00, 0, 0, 0, 0, 1, 1, 32'h400,  0, 1);
        add("fl_p11",    1, 0, 0, 11, 1, 0, 2'b00, 0, 0, 0, 0, 1, 2, 32'hC00,  0, 1);
        add("fl_p12",    1, 0, 0, 12, 1, 0, 2'b00, 0, 0, 0, 0, 1, 3, 32'h1C00, 0, 1);
        add("fl_p13",    1, 0, 0, 13, 1, 0, 2'b00, 0, 0, 0, 0, 1, 4, 32'h3C00, 0, 1);
        add("fl_drain",  1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0,  0, 4, 32'h3C00, 1, 1);
        add("fl_drfl",   1, 0, 0, 14, 1, 0, 2'b01, 10, 0, 0, 1, 0, 0, 32'h0,  0, 1);
        add("fl_serf",   1, 0, 0, 15, 1, 1, 2'b00, 0, 0, 0, 0,  1, 1, 32'h8000, 1, 1);
        add("fl_serfl",  1, 0, 0, 16, 1, 0, 2'b01, 15, 0, 0, 1, 0, 0, 32'h0,  0, 1);
        add("fl_after",  1, 0, 0, 16, 1, 0, 2'b00, 0, 0, 0, 0,  1, 1, 32'h10000, 0, 1);

        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", issue_ready, 1);
        check("rst_inflight", inflight, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_underflow, 0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (tbl[i]) begin
            @(negedge CLK);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wen, tbl[i].ser,
                  tbl[i].wbv, tbl[i].wb0, tbl[i].wb1, tbl[i].sdone, tbl[i].fl);
            #1;
            check({tbl[i].name, "/ready"}, issue_ready, tbl[i].e_ready);
            @(posedge CLK);
            #1;
            check({tbl[i].name, "/inflight"}, inflight, tbl[i].e_infl);
            check({tbl[i].name, "/pending"}, pending, tbl[i].e_pend);
            check({tbl[i].name, "/busy"}, busy, tbl[i].e_busy);
            check({tbl[i].name, "/err"}, err_underflow, tbl[i].e_err);
        end

        // Async reset while draining (inflight 1 from x16).
        @(negedge CLK);
        drive(1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        #1;
        check("ar_drain/ready", issue_ready, 0);
        @(posedge CLK);
        #1;
        check("ar_drain/busy", busy, 1);
        #2;
        nRST = 1'b0;
        #1;
        check("ar_drain/busy_rst", busy, 0);
        check("ar_drain/inflight_rst", inflight, 0);
        check("ar_drain/pending_rst", pending, 0);
        check("ar_drain/err_rst", err_underflow, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Serialising head with empty machine goes straight to SERIAL; reset it asynchronously.
        #1;
        check("ar_ser/ready", issue_ready, 1);
        @(posedge CLK);
        #1;
        check("ar_ser/busy", busy, 1);
        drive(1, 0, 0, 4, 1, 0, 2'b00, 0, 0, 0, 0);
        #1;
        check("ar_ser/blocked", issue_ready, 0);
        #1;
        nRST = 1'b0;
        #1;
        check("ar_ser/busy_rst", busy, 0);
        check("ar_ser/ready_rst", issue_ready, 1);
        @(negedge CLK);
        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
